// File: rtl/lane_training_fsm.sv
// Lane initialisation sequencer on the sideband clock: DISCONNECTED -> TRAINING -> GEN4_TS1 -> GEN4_TS2 -> CL0.
// Define LANE_FSM_ERR_CNT_EN to build the saturating training-error counter on err_cnt.
module lane_training_fsm #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       tdisconnect_tx_min,
    input  logic       tdisabled_min,
    input  logic       tgen4_ts1_timeout,
    input  logic       tgen4_ts2_timeout,
    input  logic       tdisconnect_rx_min,
    input  logic       tconnect_rx_min,
    input  logic       ttraining_error_timeout,
    input  logic       disable_req,
    input  logic       sb_done,
    input  logic       ts1_done,
    input  logic       ts2_done,
    output logic       disconnected_s,
    output logic       fsm_disabled,
    output logic       fsm_training,
    output logic       ts1_gen4_s,
    output logic       ts2_gen4_s,
    output logic       sbtx,
    output logic       cl0_s,
    output logic       train_err,
    output logic [2:0] state,
    output logic [7:0] err_cnt
);

    // state | meaning
    // DISC 0 SBTX low, waiting for connect | TRAIN 1 sideband training | TS1 2 / TS2 3 ordered sets | CL0 4 link up | DIS 5 SBTX low, disabled
    typedef enum logic [2:0] {
        ST_DISC  = 3'd0,
        ST_TRAIN = 3'd1,
        ST_TS1   = 3'd2,
        ST_TS2   = 3'd3,
        ST_CL0   = 3'd4,
        ST_DIS   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [2:0] edge_prev_q;
    logic [2:0] stb;
    logic       sync_tx_min;
    logic       dis_stb, ts1_to_stb, ts2_to_stb;
    logic       tx_met_q, dis_met_q;
    logic       tx_met, dis_met;
    logic       timeout_cond, timeout_hit;

    // bit 0 is a level; bits 3:1 are edge-detected into single-cycle strobes
    always_ff @(posedge sb_clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            edge_prev_q <= '0;
        end else begin
            sync_q[0] <= {tgen4_ts2_timeout, tgen4_ts1_timeout, tdisabled_min, tdisconnect_tx_min};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            edge_prev_q <= sync_q[SYNC_STAGES-1][3:1];
        end
    end

    assign sync_tx_min = sync_q[SYNC_STAGES-1][0];
    assign stb         = sync_q[SYNC_STAGES-1][3:1] & ~edge_prev_q;
    assign dis_stb     = stb[0];
    assign ts1_to_stb  = stb[1];
    assign ts2_to_stb  = stb[2];

    always_comb begin
        state_d      = state_q;
        timeout_hit  = 1'b0;
        timeout_cond = 1'b0;
        tx_met       = tx_met_q  | ((state_q == ST_DISC) & sync_tx_min);
        dis_met      = dis_met_q | ((state_q == ST_DIS) & dis_stb);
        case (state_q)
            ST_TRAIN: timeout_cond = ttraining_error_timeout;
            ST_TS1:   timeout_cond = ts1_to_stb;
            ST_TS2:   timeout_cond = ts2_to_stb;
            default:  timeout_cond = 1'b0;
        endcase
        if (disable_req && state_q != ST_DIS) begin
            state_d = ST_DIS;
        end else if (tdisconnect_rx_min && (state_q inside {ST_TRAIN, ST_TS1, ST_TS2, ST_CL0})) begin
            state_d = ST_DISC;
        end else if (timeout_cond) begin
            state_d     = ST_DISC;
            timeout_hit = 1'b1;
        end else begin
            case (state_q)
                ST_DISC:  if (tx_met && tconnect_rx_min) state_d = ST_TRAIN;
                ST_TRAIN: if (sb_done)  state_d = ST_TS1;
                ST_TS1:   if (ts1_done) state_d = ST_TS2;
                ST_TS2:   if (ts2_done) state_d = ST_CL0;
                ST_CL0:   state_d = ST_CL0;
                ST_DIS:   if (!disable_req && dis_met) state_d = ST_DISC;
                default:  state_d = ST_DISC;
            endcase
        end
    end

    always_ff @(posedge sb_clk) begin
        if (rst) begin
            state_q        <= ST_DISC;
            tx_met_q       <= 1'b0;
            dis_met_q      <= 1'b0;
            disconnected_s <= 1'b1;
            fsm_disabled   <= 1'b0;
            fsm_training   <= 1'b0;
            ts1_gen4_s     <= 1'b0;
            ts2_gen4_s     <= 1'b0;
            sbtx           <= 1'b0;
            cl0_s          <= 1'b0;
            train_err      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tx_met_q       <= (state_q == ST_DISC && state_d == ST_DISC) ? tx_met : 1'b0;
            dis_met_q      <= (state_q == ST_DIS && state_d == ST_DIS) ? dis_met : 1'b0;
            disconnected_s <= (state_d == ST_DISC);
            fsm_disabled   <= (state_d == ST_DIS);
            fsm_training   <= (state_d == ST_TRAIN);
            ts1_gen4_s     <= (state_d == ST_TS1);
            ts2_gen4_s     <= (state_d == ST_TS2);
            sbtx           <= !(state_d == ST_DISC || state_d == ST_DIS);
            cl0_s          <= (state_d == ST_CL0);
            train_err      <= timeout_hit;
        end
    end

    assign state = state_q;

`ifdef LANE_FSM_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge sb_clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (timeout_hit && err_cnt_q != 8'hFF) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_lane_training_fsm.sv
// Random and directed stimulus for lane_training_fsm, checked every cycle against a rule-level reference model.
module tb_lane_training_fsm;

    localparam int S = 2;

    logic       sb_clk = 1'b0;
    logic       rst = 1'b1;
    logic       tdisconnect_tx_min = 0, tdisabled_min = 0, tgen4_ts1_timeout = 0, tgen4_ts2_timeout = 0;
    logic       tdisconnect_rx_min = 0, tconnect_rx_min = 0, ttraining_error_timeout = 0;
    logic       disable_req = 0, sb_done = 0, ts1_done = 0, ts2_done = 0;
    logic       disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s, ts2_gen4_s;
    logic       sbtx, cl0_s, train_err;
    logic [2:0] state;
    logic [7:0] err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: state number, flags, error count, clk_b input histories (newest first)
    int m_st = 0;
    bit m_txf = 0, m_disf = 0, m_terr = 0;
    int m_cnt = 0;
    bit q_tx[$], q_dis[$], q_t1[$], q_t2[$];

    lane_training_fsm #(.SYNC_STAGES(S)) dut (
        .sb_clk(sb_clk), .rst(rst),
        .tdisconnect_tx_min(tdisconnect_tx_min), .tdisabled_min(tdisabled_min),
        .tgen4_ts1_timeout(tgen4_ts1_timeout), .tgen4_ts2_timeout(tgen4_ts2_timeout),
        .tdisconnect_rx_min(tdisconnect_rx_min), .tconnect_rx_min(tconnect_rx_min),
        .ttraining_error_timeout(ttraining_error_timeout), .disable_req(disable_req),
        .sb_done(sb_done), .ts1_done(ts1_done), .ts2_done(ts2_done),
        .disconnected_s(disconnected_s), .fsm_disabled(fsm_disabled), .fsm_training(fsm_training),
        .ts1_gen4_s(ts1_gen4_s), .ts2_gen4_s(ts2_gen4_s), .sbtx(sbtx), .cl0_s(cl0_s),
        .train_err(train_err), .state(state), .err_cnt(err_cnt)
    );

    always #5 sb_clk = ~sb_clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_hist();
        q_tx.delete(); q_dis.delete(); q_t1.delete(); q_t2.delete();
        repeat (S + 1) begin
            q_tx.push_back(1'b0); q_dis.push_back(1'b0); q_t1.push_back(1'b0); q_t2.push_back(1'b0);
        end
    endtask

    // one sb_clk edge worth of the lane rules, using the inputs currently applied
    task automatic model_edge();
        bit s_tx, dis_stb, t1_stb, t2_stb, tmo, txmet, dismet, link_phase;
        int nxt;
        if (rst) begin
            m_st = 0; m_txf = 0; m_disf = 0; m_terr = 0; m_cnt = 0;
            clear_hist();
            return;
        end
        s_tx    = q_tx[S-1];
        dis_stb = q_dis[S-1] && !q_dis[S];
        t1_stb  = q_t1[S-1] && !q_t1[S];
        t2_stb  = q_t2[S-1] && !q_t2[S];
        tmo     = (m_st == 1 && ttraining_error_timeout) || (m_st == 2 && t1_stb) || (m_st == 3 && t2_stb);
        txmet   = m_txf || (m_st == 0 && s_tx);
        dismet  = m_disf || (m_st == 5 && dis_stb);
        link_phase = (m_st >= 1 && m_st <= 4);
        nxt = m_st;
        m_terr = 0;
        if (disable_req && m_st != 5) nxt = 5;
        else if (tdisconnect_rx_min && link_phase) nxt = 0;
        else if (tmo) begin nxt = 0; m_terr = 1; end
        else if (m_st == 0 && txmet && tconnect_rx_min) nxt = 1;
        else if (m_st == 1 && sb_done) nxt = 2;
        else if (m_st == 2 && ts1_done) nxt = 3;
        else if (m_st == 3 && ts2_done) nxt = 4;
        else if (m_st == 5 && !disable_req && dismet) nxt = 0;
        m_txf  = (m_st == 0 && nxt == 0) ? txmet : 1'b0;
        m_disf = (m_st == 5 && nxt == 5) ? dismet : 1'b0;
`ifdef LANE_FSM_ERR_CNT_EN
        if (m_terr && m_cnt < 255) m_cnt++;
`endif
        m_st = nxt;
        q_tx.push_front(tdisconnect_tx_min); void'(q_tx.pop_back());
        q_dis.push_front(tdisabled_min);     void'(q_dis.pop_back());
        q_t1.push_front(tgen4_ts1_timeout);  void'(q_t1.pop_back());
        q_t2.push_front(tgen4_ts2_timeout);  void'(q_t2.pop_back());
    endtask

    task automatic tick();
        model_edge();
        @(posedge sb_clk);
        #1;
        check_val("state", state, m_st);
        check_val("disconnected_s", disconnected_s, m_st == 0);
        check_val("fsm_training", fsm_training, m_st == 1);
        check_val("ts1_gen4_s", ts1_gen4_s, m_st == 2);
        check_val("ts2_gen4_s", ts2_gen4_s, m_st == 3);
        check_val("cl0_s", cl0_s, m_st == 4);
        check_val("fsm_disabled", fsm_disabled, m_st == 5);
        check_val("sbtx", sbtx, !(m_st == 0 || m_st == 5));
        check_val("train_err", train_err, m_terr);
        check_val("err_cnt", err_cnt, m_cnt);
    endtask

    task automatic idle_inputs();
        tdisconnect_tx_min = 0; tdisabled_min = 0; tgen4_ts1_timeout = 0; tgen4_ts2_timeout = 0;
        tdisconnect_rx_min = 0; tconnect_rx_min = 0; ttraining_error_timeout = 0;
        disable_req = 0; sb_done = 0; ts1_done = 0; ts2_done = 0;
    endtask

    task automatic pulse_sb(input int which);
        case (which)
            0: sb_done = 1;
            1: ts1_done = 1;
            2: ts2_done = 1;
            default: tconnect_rx_min = 1;
        endcase
        tick();
        sb_done = 0; ts1_done = 0; ts2_done = 0; tconnect_rx_min = 0;
    endtask

    // walks the lane from wherever the model says it is to the target state
    task automatic bring_to(input int target);
        idle_inputs();
        repeat (4) tick();
        for (int k = 0; k < 3 && m_st == 5; k++) begin
            tdisabled_min = 1; tick(); tdisabled_min = 0;
            repeat (4) tick();
        end
        if (m_st != 0) begin
            tdisconnect_rx_min = 1; tick(); tdisconnect_rx_min = 0;
        end
        tdisconnect_tx_min = 1;
        repeat (4) tick();
        pulse_sb(3);
        tdisconnect_tx_min = 0;
        if (target >= 2) pulse_sb(0);
        if (target >= 3) pulse_sb(1);
        if (target >= 4) pulse_sb(2);
        check_val("bring_to", state, target);
    endtask

    initial begin
        clear_hist();
        rst = 1;
        repeat (2) tick();
        check_val("reset_state", state, 0);
        check_val("reset_disc", disconnected_s, 1);
        rst = 0;

        // reset release and connect
        tdisconnect_tx_min = 1;
        repeat (5) tick();
        pulse_sb(3);
        tdisconnect_tx_min = 0;
        check_val("connect_state", state, 1);
        check_val("connect_sbtx", sbtx, 1);
        check_val("connect_disc", disconnected_s, 0);

        // full bring-up, strobes 10 cycles apart
        for (int s = 0; s < 3; s++) begin
            pulse_sb(s);
            check_val("bringup_step", state, s + 2);
            repeat (9) tick();
        end
        check_val("bringup_cl0", cl0_s, 1);

        // TS1 timeout through the synchroniser: 3 cycles of latency
        bring_to(2);
        tgen4_ts1_timeout = 1; tick(); tgen4_ts1_timeout = 0;
        tick();
        check_val("ts1_to_not_yet", state, 2);
        tick();
        check_val("ts1_to_state", state, 0);
        check_val("ts1_to_err", train_err, 1);
        tick();
        check_val("ts1_to_err_one", train_err, 0);

        // timeout beats progress; disable beats timeout
        bring_to(1);
        ttraining_error_timeout = 1; sb_done = 1; tick();
        ttraining_error_timeout = 0; sb_done = 0;
        check_val("tmo_vs_done", state, 0);
        check_val("tmo_vs_done_err", train_err, 1);
        bring_to(1);
        ttraining_error_timeout = 1; sb_done = 1; disable_req = 1; tick();
        ttraining_error_timeout = 0; sb_done = 0; disable_req = 0;
        check_val("dis_vs_tmo", state, 5);
        check_val("dis_vs_tmo_err", train_err, 0);

        // disabled exit waits for the minimum-time strobe
        bring_to(4);
        disable_req = 1; repeat (2) tick(); disable_req = 0;
        repeat (20) tick();
        check_val("dis_hold", state, 5);
        tdisabled_min = 1; tick(); tdisabled_min = 0;
        tick();
        check_val("dis_hold_sbtx", sbtx, 0);
        tick();
        check_val("dis_exit", state, 0);

        // randomized phase
        idle_inputs();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 39) == 0) disable_req = !disable_req;
            if ($urandom_range(0, 7) == 0) tdisconnect_tx_min = !tdisconnect_tx_min;
            tdisabled_min           = ($urandom_range(0, 19) == 0);
            tgen4_ts1_timeout       = ($urandom_range(0, 24) == 0);
            tgen4_ts2_timeout       = ($urandom_range(0, 24) == 0);
            tdisconnect_rx_min      = ($urandom_range(0, 59) == 0);
            tconnect_rx_min         = ($urandom_range(0, 2) == 0);
            ttraining_error_timeout = ($urandom_range(0, 39) == 0);
            sb_done                 = ($urandom_range(0, 5) == 0);
            ts1_done                = ($urandom_range(0, 5) == 0);
            ts2_done                = ($urandom_range(0, 5) == 0);
            tick();
        end
        rst = 0;

        // repeated TS2 timeouts drive the counter into saturation
        for (int n = 0; n < 260; n++) begin
            bring_to(3);
            tgen4_ts2_timeout = 1; tick(); tgen4_ts2_timeout = 0;
            repeat (2) tick();
        end
        tick();
`ifdef LANE_FSM_ERR_CNT_EN
        check_val("err_cnt_sat", err_cnt, 255);
`else
        check_val("err_cnt_off", err_cnt, 0);
`endif

        rst = 1; tick(); rst = 0;
        check_val("err_cnt_rst", err_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
